voxel_pixel_sink: RTL
=====================

# voxel_pixel_sink

Receiving end of the raycaster pixel write stream. Captures every `pixel_write_en` beat (address plus three 32-bit pixel words) into a FIFO and drains it to the framebuffer memory port over a valid/ready handshake. It turns the fire-and-forget `frame_done` pulse into a `frame_committed` pulse. That pulse fires only after every pixel of the finished frame has been accepted by memory. It sits between the raycaster core and the host framebuffer memory.

## Interface
- `FIFO_DEPTH`, 16: entries; power of two, at least 4.
- `LEVEL_W`, $clog2(FIFO_DEPTH)+1: width of the level output.
- `clk`  in  1: single clock.
- `rst`  in  1: synchronous reset, active-high.
- `pixel_write_en`  in  1: pixel beat valid. No backpressure to the source.
- `pixel_addr`  in  32: framebuffer address of the beat.
- `pixel_word0` / `pixel_word1` / `pixel_word2`  in  32 each: pixel payload.
- `frame_done`  in  1: one-cycle end-of-frame pulse from the core.
- `mem_valid`  out  1: head entry available.
- `mem_addr`  out  32: head address.
- `mem_data`  out  96: head payload as {word2, word1, word0}.
- `mem_ready`  in  1: memory accepts the head entry this cycle.
- `frame_committed`  out  1: one-cycle pulse; all beats of the frame have been accepted.
- `frame_overflowed`  out  1: valid only with `frame_committed`. It is set if any beat of that frame was dropped.
- `frame_count`  out  16: committed frames; wraps at 0xFFFF to 0.
- `drop_count`  out  16: total dropped beats; saturates at 0xFFFF.
- `done_lost`  out  1: sticky. Set when a `frame_done` arrives while a commit is pending.
- `fifo_level`  out  LEVEL_W: current occupancy.

## Operation
- **Push.** Push when `pixel_write_en` is high. Rejected only if the level is `FIFO_DEPTH` and no pop occurs in the same cycle. A push and a pop in the same cycle while full are both accepted and the level is unchanged.
- **Drop.** A rejected beat is discarded. `drop_count` increments, saturating. The per-frame overflow flag is set.
- **Pop.** Pop on `mem_valid && mem_ready`. `mem_valid` equals FIFO not empty. `mem_addr` and `mem_data` stay stable while `mem_valid && !mem_ready`.
- **FSM states.**
  - RUN: no commit pending.
  - DRAIN: waiting for the marked beats to pop.
  - COMMIT: single cycle that raises `frame_committed`.
- **RUN to DRAIN.** On `frame_done` in RUN, `remaining` is loaded with the post-cycle level. That value includes any beat pushed in the same cycle and excludes any beat popped in the same cycle. The overflow flag is snapshot (including a drop in that same cycle) and then cleared.
- **Empty at done.** If `remaining` is 0, the FSM goes straight to COMMIT.
- **DRAIN.** `remaining` decrements on each pop. The FSM moves to COMMIT on the cycle in which the pop takes `remaining` from 1 to 0.
- **Next frame during DRAIN.** Beats arriving in DRAIN belong to the next frame. They are pushed normally, and their drops set the new frame's overflow flag.
- **Lost done.** A `frame_done` in DRAIN or COMMIT is ignored and sets `done_lost`.
- **COMMIT.** `frame_committed` is 1 for that cycle and `frame_overflowed` equals the snapshot. `frame_count` increments in the same edge. Next state is RUN.

## Timing
- Push-to-visible latency is 1: a beat pushed on edge N gives `mem_valid` high after edge N.
- Fall-through to an empty FIFO is not combinational.
- `frame_committed` is asserted in the cycle after the edge that performs the final marked pop. With an empty FIFO, it is asserted in the cycle after `frame_done`.
- Minimum done-to-commit spacing is 1 cycle. Back-to-back `frame_done` in consecutive cycles gives one commit plus `done_lost`.
- Reset values:
  - Outputs: `mem_valid`=0, `frame_committed`=0, `frame_overflowed`=0, `frame_count`=0, `drop_count`=0, `done_lost`=0, `fifo_level`=0.
  - FSM state is RUN.
  - FIFO pointers are 0, and entries are discarded.
- Reset mid-DRAIN abandons the pending commit and emits no pulse.
- `mem_data`/`mem_addr` are don't-care while `mem_valid`=0.

## Structure
- Package `voxel_fb_pkg`:
  - `pixel_beat_t` packed struct {addr[31:0], word2, word1, word0}, 128 bits.
  - `sink_state_t` enum {RUN, DRAIN, COMMIT}.
  - `DROP_SAT` = 16'hFFFF.
- Sub-module `voxel_pixel_fifo`: synchronous FIFO of `pixel_beat_t` with registered read data and same-cycle push/pop. It exposes `level`, `empty` and `full`. The top handles drop, marker and FSM logic.

## Test plan
- Five beats with addresses 0..4, then `frame_done`, `mem_ready` held 1 → five pops in order; `frame_committed` on the cycle after the 5th pop; `frame_overflowed`=0; `frame_count`=1.
- `mem_ready`=0, 20 beats into depth 16, then `frame_done` → level 16, `drop_count`=4. Raise `mem_ready` → commit after 16 pops with `frame_overflowed`=1.
- `frame_done` with the FIFO empty → `frame_committed` exactly 1 cycle later; `frame_count` increments.
- A beat and `frame_done` in the same cycle, plus three beats during DRAIN → the commit arrives after 1 pop. The three later beats remain; the level is 3 at the commit.
- A second `frame_done` during DRAIN → single commit, `done_lost`=1. `rst` asserted mid-DRAIN → no pulse, all outputs return to their reset values the next cycle.

Source files
------------

// File: rtl/voxel_fb_pkg.sv
// Shared types for the raycaster pixel sink: the beat that travels through the FIFO and the commit FSM states.
package voxel_fb_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] word2;
    logic [31:0] word1;
    logic [31:0] word0;
  } pixel_beat_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    COMMIT = 2'd2
  } sink_state_t;

  localparam logic [15:0] DROP_SAT = 16'hFFFF;

endpackage

// File: rtl/voxel_pixel_fifo.sv
// Synchronous FIFO of pixel beats. The head is held in a register so the
// memory port sees stable data. A push and a pop in the same cycle are both accepted.
module voxel_pixel_fifo
  import voxel_fb_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  pixel_beat_t        push_data,
  input  logic               pop,
  output pixel_beat_t        head,
  output logic [LEVEL_W-1:0] level,
  output logic               empty,
  output logic               full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LEVEL_W-1:0] FULL_LVL = LEVEL_W'(DEPTH);

  pixel_beat_t        mem_r [DEPTH];
  pixel_beat_t        head_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [LEVEL_W-1:0] level_r;
  logic [PTR_W-1:0]   rd_ptr_next_s;
  logic [LEVEL_W-1:0] level_next_s;
  logic               push_ok_s;
  logic               pop_ok_s;

  assign empty     = (level_r == {LEVEL_W{1'b0}});
  assign full      = (level_r == FULL_LVL);
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);
  assign head      = head_r;
  assign level     = level_r;

  // next read pointer and occupancy
  always_comb begin
    rd_ptr_next_s = rd_ptr_r;
    level_next_s  = level_r;
    if (pop_ok_s) begin
      rd_ptr_next_s = rd_ptr_r + PTR_W'(1'b1);
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end
    if (push_ok_s && !pop_ok_s) begin
      level_next_s = level_r + LEVEL_W'(1'b1);
    end else if (!push_ok_s && pop_ok_s) begin
      level_next_s = level_r - LEVEL_W'(1'b1);
    end else begin
      level_next_s = level_r;
    end
  end

  // storage array; contents are discarded on reset
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // pointers, level and head register
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LEVEL_W{1'b0}};
      head_r   <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      rd_ptr_r <= rd_ptr_next_s;
      level_r  <= level_next_s;
      // a push into an (effectively) empty FIFO becomes the new head directly
      if (push_ok_s && (level_next_s == LEVEL_W'(1'b1))) begin
        head_r <= push_data;
      end else begin
        head_r <= mem_r[rd_ptr_next_s];
      end
    end
  end

endmodule

// File: rtl/voxel_pixel_sink.sv
// Pixel write sink: buffers raycaster beats toward framebuffer memory and turns
// frame_done into frame_committed once every beat of that frame has been accepted.
module voxel_pixel_sink
  import voxel_fb_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LEVEL_W    = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pixel_write_en,
  input  logic [31:0]        pixel_addr,
  input  logic [31:0]        pixel_word0,
  input  logic [31:0]        pixel_word1,
  input  logic [31:0]        pixel_word2,
  input  logic               frame_done,
  output logic               mem_valid,
  output logic [31:0]        mem_addr,
  output logic [95:0]        mem_data,
  input  logic               mem_ready,
  output logic               frame_committed,
  output logic               frame_overflowed,
  output logic [15:0]        frame_count,
  output logic [15:0]        drop_count,
  output logic               done_lost,
  output logic [LEVEL_W-1:0] fifo_level
);

  pixel_beat_t        beat_s;
  pixel_beat_t        head_s;
  logic [LEVEL_W-1:0] level_s;
  logic [LEVEL_W-1:0] level_next_s;
  logic               fifo_empty_s;
  logic               fifo_full_s;
  logic               pop_s;
  logic               drop_s;
  logic               push_ok_s;

  sink_state_t        state_r;
  sink_state_t        state_next_s;
  logic [LEVEL_W-1:0] remaining_r;
  logic [LEVEL_W-1:0] remaining_next_s;
  logic               load_s;
  logic               ovf_r;
  logic               snap_r;
  logic               committed_r;
  logic               overflowed_r;
  logic [15:0]        frame_count_r;
  logic [15:0]        drop_count_r;
  logic               done_lost_r;

  assign beat_s    = {pixel_addr, pixel_word2, pixel_word1, pixel_word0};
  assign pop_s     = !fifo_empty_s && mem_ready;
  assign drop_s    = pixel_write_en && fifo_full_s && !pop_s;
  assign push_ok_s = pixel_write_en && !drop_s;

  voxel_pixel_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .LEVEL_W (LEVEL_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pixel_write_en),
    .push_data (beat_s),
    .pop       (pop_s),
    .head      (head_s),
    .level     (level_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s)
  );

  // post-cycle occupancy used to mark the finished frame's beats
  always_comb begin
    level_next_s = level_s;
    if (push_ok_s && !pop_s) begin
      level_next_s = level_s + LEVEL_W'(1'b1);
    end else if (!push_ok_s && pop_s) begin
      level_next_s = level_s - LEVEL_W'(1'b1);
    end else begin
      level_next_s = level_s;
    end
  end

  // commit FSM next-state logic
  always_comb begin
    state_next_s     = state_r;
    remaining_next_s = remaining_r;
    load_s           = 1'b0;
    case (state_r)
      RUN: begin
        if (frame_done) begin
          load_s           = 1'b1;
          remaining_next_s = level_next_s;
          state_next_s     = (level_next_s == {LEVEL_W{1'b0}}) ? COMMIT : DRAIN;
        end else begin
          state_next_s = RUN;
        end
      end
      DRAIN: begin
        if (pop_s) begin
          remaining_next_s = remaining_r - LEVEL_W'(1'b1);
          state_next_s     = (remaining_r == LEVEL_W'(1'b1)) ? COMMIT : DRAIN;
        end else begin
          state_next_s = DRAIN;
        end
      end
      COMMIT:  state_next_s = RUN;
      default: state_next_s = RUN;
    endcase
  end

  // state, overflow tracking, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= RUN;
      remaining_r   <= {LEVEL_W{1'b0}};
      ovf_r         <= 1'b0;
      snap_r        <= 1'b0;
      committed_r   <= 1'b0;
      overflowed_r  <= 1'b0;
      frame_count_r <= 16'h0000;
      drop_count_r  <= 16'h0000;
      done_lost_r   <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      remaining_r <= remaining_next_s;
      // a drop in the done cycle still belongs to the finished frame
      if (load_s) begin
        snap_r <= ovf_r || drop_s;
        ovf_r  <= 1'b0;
      end else if (drop_s) begin
        ovf_r <= 1'b1;
      end
      committed_r  <= (state_next_s == COMMIT);
      overflowed_r <= (state_next_s == COMMIT) && (load_s ? (ovf_r || drop_s) : snap_r);
      if (state_next_s == COMMIT) begin
        frame_count_r <= frame_count_r + 16'h0001;
      end
      if (drop_s && (drop_count_r != DROP_SAT)) begin
        drop_count_r <= drop_count_r + 16'h0001;
      end
      if (frame_done && (state_r != RUN)) begin
        done_lost_r <= 1'b1;
      end
    end
  end

  assign mem_valid        = !fifo_empty_s;
  assign mem_addr         = head_s.addr;
  assign mem_data         = {head_s.word2, head_s.word1, head_s.word0};
  assign frame_committed  = committed_r;
  assign frame_overflowed = overflowed_r;
  assign frame_count      = frame_count_r;
  assign drop_count       = drop_count_r;
  assign done_lost        = done_lost_r;
  assign fifo_level       = level_s;

endmodule
